// File: rtl/spwm_ctrl_if.sv
// spwm_ctrl_if -- command/status bundle between a supervisor and spwm_ctrl.
//
// Parameters:
//   AMP_W  : modulation-index width (must match spwm_ctrl.AMP_W)
//   FREQ_W : phase-increment width  (must match spwm_ctrl.FREQ_W)
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   start, stop      in  : level requests to ramp up / ramp down
//   fault, fault_clr in  : external fault and fault acknowledge pulse
//   amp_target       in  : requested modulation index
//   freq_target      in  : requested phase increment
//   amp_step         in  : amplitude change per ramp tick (0 means 1)
//   amp_out          out : modulation index to the SPWM generator
//   freq_out         out : phase increment to the SPWM generator
//   pwm_en           out : gate enable for the SPWM generator
//   at_target        out : high in RUN while amp_out equals amp_target
//   state            out : IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, FAULT=4
//
// Modports: master = supervisor side, slave = spwm_ctrl side.
interface spwm_ctrl_if #(
  parameter int AMP_W  = 8,
  parameter int FREQ_W = 16
);
  logic              start;
  logic              stop;
  logic              fault;
  logic              fault_clr;
  logic [AMP_W-1:0]  amp_target;
  logic [FREQ_W-1:0] freq_target;
  logic [AMP_W-1:0]  amp_step;
  logic [AMP_W-1:0]  amp_out;
  logic [FREQ_W-1:0] freq_out;
  logic              pwm_en;
  logic              at_target;
  logic [2:0]        state;

  modport master (
    output start, stop, fault, fault_clr, amp_target, freq_target, amp_step,
    input  amp_out, freq_out, pwm_en, at_target, state
  );

  modport slave (
    input  start, stop, fault, fault_clr, amp_target, freq_target, amp_step,
    output amp_out, freq_out, pwm_en, at_target, state
  );
endinterface

// File: rtl/spwm_ctrl.sv
// spwm_ctrl -- soft-start / soft-stop supervisor for an SPWM generator.
//
// Ramps the modulation index up to a target on start, slews it while
// running, ramps it down to zero on stop and kills the output on fault.
// Amplitude changes happen only on ramp ticks, one every PRESCALE clocks.
//
// Parameters:
//   PRESCALE : clk cycles per ramp tick (>= 2)
//   AMP_W    : modulation-index width
//   FREQ_W   : phase-increment width
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : spwm_ctrl_if.slave (commands in, amp/freq/enable/status out)
//
// Build option:
//   SPWM_CTRL_FAULT_LATCH_EN defined   -> FAULT is left only when fault_clr=1
//                                         and fault=0 on the same edge.
//   SPWM_CTRL_FAULT_LATCH_EN undefined -> FAULT is left on the first edge
//                                         with fault=0; fault_clr is ignored.
module spwm_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int AMP_W    = 8,
  parameter int FREQ_W   = 16
) (
  input logic          clk,
  input logic          rst,
  spwm_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              tick;
  logic [AMP_W-1:0]  amp_reg, amp_next;
  logic [FREQ_W-1:0] freq_reg, freq_next;
  logic              pwm_en_reg, pwm_en_next;
  logic              at_target_reg, at_target_next;

  // ---------------------------------------------------------------------
  // Free-running tick prescaler (runs in every state)
  // ---------------------------------------------------------------------
  assign tick = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Saturating amplitude arithmetic, one bit wider to catch carry/borrow
  // ---------------------------------------------------------------------
  logic [AMP_W-1:0] step_eff;
  logic [AMP_W:0]   sum_w, diff_w;
  logic [AMP_W-1:0] up_sat;     // amp + step, clamped at amp_target
  logic [AMP_W-1:0] down_sat;   // amp - step, clamped at 0
  logic [AMP_W-1:0] slew_down;  // amp - step, clamped at amp_target
  logic [AMP_W-1:0] run_slew;

  assign step_eff  = (bus.amp_step == '0) ? AMP_W'(1) : bus.amp_step;
  assign sum_w     = {1'b0, amp_reg} + {1'b0, step_eff};
  assign diff_w    = {1'b0, amp_reg} - {1'b0, step_eff};
  assign up_sat    = (sum_w >= {1'b0, bus.amp_target}) ? bus.amp_target
                                                       : sum_w[AMP_W-1:0];
  assign down_sat  = diff_w[AMP_W] ? '0 : diff_w[AMP_W-1:0];
  // While running, a down-slew must not undershoot the target either.
  assign slew_down = (diff_w[AMP_W] || (diff_w[AMP_W-1:0] < bus.amp_target))
                     ? bus.amp_target : diff_w[AMP_W-1:0];
  assign run_slew  = (amp_reg < bus.amp_target) ? up_sat :
                     (amp_reg > bus.amp_target) ? slew_down : amp_reg;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic. Fault outranks everything; stop outranks start.
  // A tick only acts on the state it finds, so an exit edge never also
  // applies a step in the new state.
  // ---------------------------------------------------------------------
`ifndef SPWM_CTRL_FAULT_LATCH_EN
  logic fault_clr_unused;
  assign fault_clr_unused = bus.fault_clr;
`endif

  always_comb begin
    state_next = state_reg;
    if (bus.fault && (state_reg != FAULT)) begin
      state_next = FAULT;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.stop) state_next = RAMP_UP;
        end
        RAMP_UP: begin
          if (bus.stop)                                    state_next = RAMP_DOWN;
          else if (tick && (up_sat == bus.amp_target))     state_next = RUN;
        end
        RUN: begin
          if (bus.stop) state_next = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (tick && (down_sat == '0)) state_next = IDLE;
        end
        FAULT: begin
`ifdef SPWM_CTRL_FAULT_LATCH_EN
          if (bus.fault_clr && !bus.fault) state_next = IDLE;
`else
          if (!bus.fault) state_next = IDLE;
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: output / datapath next-value logic
  // ---------------------------------------------------------------------
  always_comb begin
    amp_next    = amp_reg;
    freq_next   = freq_reg;
    pwm_en_next = pwm_en_reg;
    if (state_next == FAULT) begin
      amp_next    = '0;
      pwm_en_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          amp_next    = '0;
          pwm_en_next = 1'b0;
          if (state_next == RAMP_UP) begin
            pwm_en_next = 1'b1;
            freq_next   = bus.freq_target;
          end
        end
        RAMP_UP: begin
          if ((state_next != RAMP_DOWN) && tick) amp_next = up_sat;
        end
        RUN: begin
          if ((state_next == RUN) && tick) begin
            amp_next  = run_slew;
            freq_next = bus.freq_target;
          end
        end
        RAMP_DOWN: begin
          if (tick) amp_next = down_sat;
          if (state_next == IDLE) pwm_en_next = 1'b0;
        end
        default: begin  // FAULT exiting to IDLE
          amp_next    = '0;
          pwm_en_next = 1'b0;
        end
      endcase
    end
    at_target_next = (state_next == RUN) && (amp_next == bus.amp_target);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amp_reg       <= '0;
      freq_reg      <= '0;
      pwm_en_reg    <= 1'b0;
      at_target_reg <= 1'b0;
    end else begin
      amp_reg       <= amp_next;
      freq_reg      <= freq_next;
      pwm_en_reg    <= pwm_en_next;
      at_target_reg <= at_target_next;
    end
  end

  assign bus.amp_out   = amp_reg;
  assign bus.freq_out  = freq_reg;
  assign bus.pwm_en    = pwm_en_reg;
  assign bus.at_target = at_target_reg;
  assign bus.state     = state_reg;

endmodule

// File: tb/tb_spwm_ctrl.sv
// tb_spwm_ctrl -- directed self-checking bench for spwm_ctrl (PRESCALE=4).
// Snapshot format: {state[2:0], pwm_en, at_target, amp_out[7:0]}.
// Honours SPWM_CTRL_FAULT_LATCH_EN for the fault-exit expectations.
module tb_spwm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spwm_ctrl_if #(.AMP_W(8), .FREQ_W(16)) bus ();

  spwm_ctrl #(.PRESCALE(4), .AMP_W(8), .FREQ_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Independent tick-timing reference: counts 0..3 from reset release.
  int tb_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [12:0] obs, exp;

  function automatic logic [12:0] snap();
    return {bus.state, bus.pwm_en, bus.at_target, bus.amp_out};
  endfunction

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  // Advance to 1 time unit after the next tick edge; call from posedge+1.
  task automatic wait_tick(input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      @(negedge clk);
      if (tb_cnt == 3) hit = 1;
    end
    if (!hit) begin
      errors++;
      $display("FAIL %s: tick wait expired got none want tick", tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.stop = 0; bus.fault = 0; bus.fault_clr = 0;
    bus.amp_target = 0; bus.freq_target = 0; bus.amp_step = 0;
    rst = 1;
    #2;
    obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
    if (obs !== exp || bus.freq_out !== 16'h0) begin
      errors++; $display("FAIL reset: got %h/%h want %h/0000", obs, bus.freq_out, exp);
    end else $display("pass reset %h", obs);
    @(negedge clk); rst = 0;
  endtask

  task automatic test_ramp_up();
    bus.amp_target = 8'd10; bus.amp_step = 8'd4; bus.freq_target = 16'h1234;
    bus.start = 1;
    edge1();
    bus.start = 0;
    obs = snap(); exp = {3'd1, 2'b10, 8'd0}; checks++;
    if (obs !== exp || bus.freq_out !== 16'h1234) begin
      errors++; $display("FAIL up_start: got %h/%h want %h/1234", obs, bus.freq_out, exp);
    end else $display("pass up_start %h", obs);
    wait_tick("up_t1");
    obs = snap(); exp = {3'd1, 2'b10, 8'd4}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_t1: got %h want %h", obs, exp); end
    else $display("pass up_t1 %h", obs);
    wait_tick("up_t2");
    obs = snap(); exp = {3'd1, 2'b10, 8'd8}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_t2: got %h want %h", obs, exp); end
    else $display("pass up_t2 %h", obs);
    wait_tick("up_t3");
    obs = snap(); exp = {3'd2, 2'b11, 8'd10}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_t3_run: got %h want %h", obs, exp); end
    else $display("pass up_t3_run %h", obs);
  endtask

  task automatic test_ramp_down();
    bus.stop = 1;
    edge1();
    obs = snap(); exp = {3'd3, 2'b10, 8'd10}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL dn_enter: got %h want %h", obs, exp); end
    else $display("pass dn_enter %h", obs);
    wait_tick("dn_t1");
    obs = snap(); exp = {3'd3, 2'b10, 8'd6}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL dn_t1: got %h want %h", obs, exp); end
    else $display("pass dn_t1 %h", obs);
    wait_tick("dn_t2");
    obs = snap(); exp = {3'd3, 2'b10, 8'd2}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL dn_t2: got %h want %h", obs, exp); end
    else $display("pass dn_t2 %h", obs);
    wait_tick("dn_t3");
    obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL dn_t3_idle: got %h want %h", obs, exp); end
    else $display("pass dn_t3_idle %h", obs);
    bus.stop = 0;
  endtask

  task automatic test_start_stop();
    bus.start = 1; bus.stop = 1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL start_stop%0d: got %h want %h", i, obs, exp); end
      else $display("pass start_stop%0d %h", i, obs);
    end
    bus.start = 0; bus.stop = 0;
  endtask

  task automatic test_fault();
    bus.amp_target = 8'd10; bus.amp_step = 8'd4; bus.start = 1;
    edge1();
    bus.start = 0;
    wait_tick("flt_t1");
    obs = snap(); exp = {3'd1, 2'b10, 8'd4}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL flt_pre: got %h want %h", obs, exp); end
    else $display("pass flt_pre %h", obs);
    bus.fault = 1;
    edge1();
    obs = snap(); exp = {3'd4, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL flt_enter: got %h want %h", obs, exp); end
    else $display("pass flt_enter %h", obs);
    bus.fault_clr = 1;  // clear while fault still present must not exit
    edge1();
    obs = snap(); exp = {3'd4, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL flt_hold: got %h want %h", obs, exp); end
    else $display("pass flt_hold %h", obs);
    bus.fault_clr = 0; bus.fault = 0;
    edge1();
`ifdef SPWM_CTRL_FAULT_LATCH_EN
    obs = snap(); exp = {3'd4, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL flt_latched: got %h want %h", obs, exp); end
    else $display("pass flt_latched %h", obs);
    bus.fault_clr = 1;
    edge1();
    bus.fault_clr = 0;
`endif
    obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL flt_exit: got %h want %h", obs, exp); end
    else $display("pass flt_exit %h", obs);
  endtask

  task automatic test_min_step_slew();
    bus.amp_target = 8'd3; bus.amp_step = 8'd0; bus.freq_target = 16'h0100; bus.start = 1;
    edge1();
    bus.start = 0;
    for (int i = 1; i <= 3; i++) begin
      wait_tick("min_step");
      obs = snap();
      exp = (i == 3) ? {3'd2, 2'b11, 8'd3} : {3'd1, 2'b10, 8'(i)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL min_step%0d: got %h want %h", i, obs, exp); end
      else $display("pass min_step%0d %h", i, obs);
    end
    bus.amp_target = 8'd9; bus.amp_step = 8'd4; bus.freq_target = 16'h0BEE;
    wait_tick("slew_up1");
    obs = snap(); exp = {3'd2, 2'b10, 8'd7}; checks++;
    if (obs !== exp || bus.freq_out !== 16'h0BEE) begin
      errors++; $display("FAIL slew_up1: got %h/%h want %h/0bee", obs, bus.freq_out, exp);
    end else $display("pass slew_up1 %h", obs);
    wait_tick("slew_up2");
    obs = snap(); exp = {3'd2, 2'b11, 8'd9}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL slew_up2_sat: got %h want %h", obs, exp); end
    else $display("pass slew_up2_sat %h", obs);
    bus.amp_target = 8'd2;
    wait_tick("slew_dn1");
    obs = snap(); exp = {3'd2, 2'b10, 8'd5}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL slew_dn1: got %h want %h", obs, exp); end
    else $display("pass slew_dn1 %h", obs);
    wait_tick("slew_dn2");
    obs = snap(); exp = {3'd2, 2'b11, 8'd2}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL slew_dn2_sat: got %h want %h", obs, exp); end
    else $display("pass slew_dn2_sat %h", obs);
    bus.stop = 1;
    edge1();
    wait_tick("stop_floor");
    obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL stop_floor: got %h want %h", obs, exp); end
    else $display("pass stop_floor %h", obs);
    bus.stop = 0;
  endtask

  task automatic test_zero_target();
    bus.amp_target = 8'd0; bus.amp_step = 8'd4; bus.start = 1;
    edge1();
    bus.start = 0;
    wait_tick("zero_run");
    obs = snap(); exp = {3'd2, 2'b11, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_run: got %h want %h", obs, exp); end
    else $display("pass zero_run %h", obs);
    bus.stop = 1;
    edge1();
    wait_tick("zero_idle");
    obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_idle: got %h want %h", obs, exp); end
    else $display("pass zero_idle %h", obs);
    bus.stop = 0;
  endtask

  task automatic test_reset_mid_ramp();
    bus.amp_target = 8'd10; bus.amp_step = 8'd4; bus.freq_target = 16'h4321; bus.start = 1;
    edge1();
    bus.start = 0;
    wait_tick("rst_pre");
    obs = snap(); exp = {3'd1, 2'b10, 8'd4}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_pre: got %h want %h", obs, exp); end
    else $display("pass rst_pre %h", obs);
    @(negedge clk); #2;
    rst = 1;
    #1;
    obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
    if (obs !== exp || bus.freq_out !== 16'h0) begin
      errors++; $display("FAIL rst_async: got %h/%h want %h/0000", obs, bus.freq_out, exp);
    end else $display("pass rst_async %h", obs);
    @(negedge clk); rst = 0;
    edge1();
    obs = snap(); exp = {3'd0, 2'b00, 8'd0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_after: got %h want %h", obs, exp); end
    else $display("pass rst_after %h", obs);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_start_stop();
    test_fault();
    test_min_step_slew();
    test_zero_target();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spwm_ctrl.md
SPWM_CTRL -- requirements
Module: spwm_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000, meaning clk cycles per ramp tick (1 kHz at 100 MHz); legal values are 2 and above.
REQ-002 SHALL have parameter AMP_W, default 8, meaning modulation-index width.
REQ-003 SHALL have parameter FREQ_W, default 16, meaning phase-increment width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: level request to ramp up and run.
REQ-007 SHALL have port stop, input, 1 bit: level request to ramp down to idle.
REQ-008 SHALL have port fault, input, 1 bit: external fault, active-high.
REQ-009 SHALL have port fault_clr, input, 1 bit: fault acknowledge pulse.
REQ-010 SHALL have port amp_target, input, AMP_W bits: requested modulation index.
REQ-011 SHALL have port freq_target, input, FREQ_W bits: requested phase increment.
REQ-012 SHALL have port amp_step, input, AMP_W bits: amplitude change per tick.
REQ-013 SHALL have port amp_out, output, AMP_W bits: modulation index to the SPWM generator.
REQ-014 SHALL have port freq_out, output, FREQ_W bits: phase increment to the SPWM generator.
REQ-015 SHALL have port pwm_en, output, 1 bit: gate enable for the SPWM generator.
REQ-016 SHALL have port at_target, output, 1 bit: high in RUN while amp_out equals amp_target.
REQ-017 SHALL have port state, output, 3 bits: encoding IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, FAULT=4.

Function
REQ-018 SHALL run a tick counter from 0 to PRESCALE-1; tick is a 1-cycle pulse when the count equals PRESCALE-1; the counter wraps to 0 and runs in every state.
REQ-019 SHALL use an effective step of 1 when amp_step is 0.
REQ-020 SHALL compute all amplitude adds and subtracts one bit wider and saturate: no overshoot of amp_target on up-steps, no underflow below 0 on down-steps.
REQ-021 In IDLE, SHALL hold amp_out=0 and pwm_en=0; start=1, stop=0 and fault=0 SHALL go to RAMP_UP, with pwm_en=1 and freq_out<=freq_target on the same edge.
REQ-022 In RAMP_UP, SHALL add the step to amp_out on each tick; when amp_out reaches amp_target it SHALL go to RUN on that edge (amp_target=0 goes to RUN on the first tick).
REQ-023 In RUN, SHALL slew amp_out toward amp_target by one step per tick in either direction and load freq_out<=freq_target on each tick.
REQ-024 stop=1 in RAMP_UP or RUN SHALL go to RAMP_DOWN; stop SHALL win over simultaneous start.
REQ-025 In RAMP_DOWN, SHALL subtract the step on each tick; the edge that makes amp_out 0 SHALL enter IDLE and clear pwm_en.
REQ-026 fault=1 in any non-FAULT state SHALL, on the next edge, enter FAULT with amp_out=0 and pwm_en=0; fault SHALL have priority over start, stop and tick.
REQ-027 at_target SHALL be registered and update on the same edge as amp_out.
REQ-028 A tick coinciding with a state transition SHALL be applied in the new state only from the following tick onward.

Reset
REQ-029 On rst=1, SHALL force state=IDLE, amp_out=0, freq_out=0, pwm_en=0, at_target=0 and tick counter=0, asynchronously and independent of clk.
REQ-030 Reset asserted mid-ramp SHALL abandon the ramp; no output SHALL retain its pre-reset value.

Configuration
REQ-031 With SPWM_CTRL_FAULT_LATCH_EN defined, FAULT SHALL exit to IDLE only on the edge where fault_clr=1 and fault=0.
REQ-032 Without SPWM_CTRL_FAULT_LATCH_EN, FAULT SHALL exit to IDLE on the first edge with fault=0, and fault_clr SHALL be ignored.

Verification (PRESCALE=4)
REQ-033 Bench SHALL check: amp_target=10, amp_step=4, start pulse -> amp_out 4, 8, 10 on successive ticks, then state=RUN and at_target=1.
REQ-034 Bench SHALL check: in RUN at amp 10, raise stop -> amp_out 6, 2, 0 on successive ticks, pwm_en=0 and state=IDLE on the edge amp reaches 0.
REQ-035 Bench SHALL check: start=stop=1 in IDLE -> state stays IDLE, pwm_en=0.
REQ-036 Bench SHALL check: fault=1 mid-RAMP_UP -> next edge state=4, amp_out=0, pwm_en=0; latch build holds until fault_clr=1 with fault=0, non-latch build returns to IDLE on the first cycle with fault=0.
REQ-037 Bench SHALL check: amp_step=0, amp_target=3 -> amp_out 1, 2, 3 on successive ticks.
REQ-038 Bench SHALL check: rst pulse mid-RAMP_UP, asserted between clock edges -> all outputs 0 immediately, state=IDLE.
